// File: rtl/apb_pkg.sv
// Shared types and helpers for the multi-slave APB master: FSM state encoding,
// select-width and watchdog-counter sizing functions, default watchdog limit.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DERR
    } apb_state_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    // Slave-select width; a single slave still needs one bit so that index 1 decodes as an error.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int limit);
        int w;
        w = clog2_min1(limit + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_multi_slave_master_if.sv
// Host request port plus APB bus bundle; the master modport is the bus-engine view,
// the slave modport is the view of whatever sits on the far side (host and peripherals).
interface apb_multi_slave_master_if #(
    parameter int ADDR_width = 8,
    parameter int DATA_width = 32,
    parameter int NUM_SLV    = 4
);
    localparam int STRB_W = DATA_width / 8;

    // host side
    logic                          start_transfer;
    logic                          rw;
    logic [ADDR_width-1:0]         addr;
    logic [DATA_width-1:0]         wdata;
    logic [STRB_W-1:0]             wstrb;
    logic [DATA_width-1:0]         rdata;
    logic                          valid;
    logic                          error;
    logic                          timeout;
    logic                          busy;

    // APB side
    logic [NUM_SLV-1:0]            P_sel;
    logic                          P_enable;
    logic                          P_write;
    logic [ADDR_width-1:0]         P_addr;
    logic [DATA_width-1:0]         P_wdata;
    logic [STRB_W-1:0]             P_strb;
    logic [NUM_SLV*DATA_width-1:0] P_rdata;
    logic [NUM_SLV-1:0]            P_ready;
    logic [NUM_SLV-1:0]            P_slverr;

    modport master (
        input  start_transfer, rw, addr, wdata, wstrb,
        input  P_rdata, P_ready, P_slverr,
        output rdata, valid, error, timeout, busy,
        output P_sel, P_enable, P_write, P_addr, P_wdata, P_strb
    );

    modport slave (
        output start_transfer, rw, addr, wdata, wstrb,
        output P_rdata, P_ready, P_slverr,
        input  rdata, valid, error, timeout, busy,
        input  P_sel, P_enable, P_write, P_addr, P_wdata, P_strb
    );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational slave decoder: the top SEL_W address bits pick one PSEL line;
// an index at or beyond NUM_SLV yields no select and raises decode_err_o.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_width = 8,
    parameter int NUM_SLV    = 4,
    parameter int SEL_W      = clog2_min1(NUM_SLV)
) (
    input  logic [ADDR_width-1:0] addr_i,
    output logic [NUM_SLV-1:0]    sel_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic                  decode_err_o
);

    // Only the top bits select; the reduction keeps the low bits visibly consumed.
    logic unused_addr;
    assign unused_addr = ^{1'b0, addr_i};

    assign idx_o = addr_i[ADDR_width-1 -: SEL_W];

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        sel_o        = '0;
        decode_err_o = 1'b1;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_o == SEL_W'(i)) begin
                sel_o[i]     = 1'b1;
                decode_err_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_multi_slave_master.sv
// APB master serving a host request port and NUM_SLV slaves (IDLE/SETUP/ACCESS/DERR).
// Define APB_TIMEOUT_EN to build the ACCESS-phase watchdog; otherwise timeout is tied low.
module apb_multi_slave_master
    import apb_pkg::*;
#(
    parameter int ADDR_width     = 8,
    parameter int DATA_width     = 32,
    parameter int NUM_SLV        = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input logic                        P_clk,
    input logic                        P_reset_n,
    apb_multi_slave_master_if.master   bus
);

    localparam int SEL_W  = clog2_min1(NUM_SLV);
    localparam int STRB_W = DATA_width / 8;

    apb_state_t            state_q, state_d;
    logic                  rw_q, rw_d;
    logic [ADDR_width-1:0] addr_q, addr_d;
    logic [DATA_width-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [NUM_SLV-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [DATA_width-1:0] rdata_q, rdata_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic [NUM_SLV-1:0]    dec_sel;
    logic [SEL_W-1:0]      dec_idx;
    logic                  dec_err;
    logic                  slv_ready;
    logic                  slv_err;
    logic [DATA_width-1:0] slv_rdata;

    // A request is only looked at in IDLE, which includes the valid cycle (back-to-back).
    assign accept = (state_q == IDLE) && bus.start_transfer;
    assign addr_d = accept ? bus.addr : addr_q;

    apb_addr_decoder #(
        .ADDR_width (ADDR_width),
        .NUM_SLV    (NUM_SLV),
        .SEL_W      (SEL_W)
    ) u_dec (
        .addr_i       (addr_d),
        .sel_o        (dec_sel),
        .idx_o        (dec_idx),
        .decode_err_o (dec_err)
    );

    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == SEL_W'(i)) begin
                slv_ready = bus.P_ready[i];
                slv_err   = bus.P_slverr[i];
                slv_rdata = bus.P_rdata[i*DATA_width +: DATA_width];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        rw_d    = accept ? bus.rw    : rw_q;
        wdata_d = accept ? bus.wdata : wdata_q;
        wstrb_d = accept ? bus.wstrb : wstrb_q;
        sel_d   = accept ? dec_sel   : sel_q;
        idx_d   = accept ? dec_idx   : idx_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        error_d = 1'b0;
`ifdef APB_TIMEOUT_EN
        timeout_d = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = dec_err ? DERR : SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (slv_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    error_d = slv_err;
                    if (!rw_q) begin
                        rdata_d = slv_rdata;
                    end
                end
`ifdef APB_TIMEOUT_EN
                // A ready on the limit cycle takes the branch above and completes normally.
                else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    valid_d   = 1'b1;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            DERR: begin
                state_d = IDLE;
                valid_d = 1'b1;
                error_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge P_clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples the pre-edge values.
        if (!P_reset_n) begin
            // NOTE: the captured request and rdata are reset too, since they drive outputs that must read 0 after reset.
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge P_clk) begin
        if (!P_reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.busy     = (state_q != IDLE);
    assign bus.P_sel    = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
    assign bus.P_enable = (state_q == ACCESS);
    assign bus.P_write  = rw_q;
    assign bus.P_addr   = addr_q;
    assign bus.P_wdata  = wdata_q;
    assign bus.P_strb   = rw_q ? wstrb_q : '0;
    assign bus.rdata    = rdata_q;
    assign bus.valid    = valid_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Directed bench for apb_multi_slave_master: a 4-slave and a 3-slave instance, vector
// table for single transfers plus hand sequences for back-to-back, decode error, watchdog and reset.
module tb_apb_multi_slave_master;

    logic P_clk;
    logic P_reset_n;

    int n_vec  = 0;
    int n_fail = 0;

    apb_multi_slave_master_if #(.ADDR_width(8), .DATA_width(32), .NUM_SLV(4)) if4 ();
    apb_multi_slave_master_if #(.ADDR_width(8), .DATA_width(32), .NUM_SLV(3)) if3 ();

    apb_multi_slave_master #(
        .ADDR_width(8), .DATA_width(32), .NUM_SLV(4), .TIMEOUT_CYCLES(8)
    ) dut4 (
        .P_clk     (P_clk),
        .P_reset_n (P_reset_n),
        .bus       (if4.master)
    );

    apb_multi_slave_master #(
        .ADDR_width(8), .DATA_width(32), .NUM_SLV(3), .TIMEOUT_CYCLES(8)
    ) dut3 (
        .P_clk     (P_clk),
        .P_reset_n (P_reset_n),
        .bus       (if3.master)
    );

    initial P_clk = 1'b0;
    always #5 P_clk = ~P_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected completion");
        $fatal(1, "simulation time limit");
    end

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        int          slv;
        logic [31:0] slv_rdata;
        logic        slv_err;
        logic [3:0]  exp_sel;
        logic [3:0]  exp_strb;
        logic        exp_error;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Selected slave answers with the given data/err/ready; the others always look ready with an error.
    task automatic drive4(input int slv, input logic [31:0] data, input logic err, input logic rdy);
        for (int i = 0; i < 4; i++) begin
            if (i == slv) begin
                if4.P_rdata[i*32 +: 32] = data;
                if4.P_ready[i]          = rdy;
                if4.P_slverr[i]         = err;
            end else begin
                if4.P_rdata[i*32 +: 32] = 32'hFFFF_FFFF;
                if4.P_ready[i]          = 1'b1;
                if4.P_slverr[i]         = 1'b1;
            end
        end
    endtask

    task automatic request4(input logic rw, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
        if4.start_transfer = 1'b1;
        if4.rw             = rw;
        if4.addr           = addr;
        if4.wdata          = wdata;
        if4.wstrb          = wstrb;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge P_clk);
        check("idle_busy", if4.busy, 1'b0);
        request4(v.rw, v.addr, v.wdata, v.wstrb);
        drive4(v.slv, v.slv_rdata, v.slv_err, 1'b0);
        @(negedge P_clk);
        if4.start_transfer = 1'b0;
        check("setup_sel",   if4.P_sel,    v.exp_sel);
        check("setup_en",    if4.P_enable, 1'b0);
        check("setup_busy",  if4.busy,     1'b1);
        check("setup_write", if4.P_write,  v.rw);
        check("setup_addr",  if4.P_addr,   v.addr);
        check("setup_wdata", if4.P_wdata,  v.wdata);
        check("setup_strb",  if4.P_strb,   v.exp_strb);
        for (int k = 1; k <= v.waits + 1; k++) begin
            @(negedge P_clk);
            check("access_sel",   if4.P_sel,    v.exp_sel);
            check("access_en",    if4.P_enable, 1'b1);
            check("access_valid", if4.valid,    1'b0);
            check("access_addr",  if4.P_addr,   v.addr);
            check("access_strb",  if4.P_strb,   v.exp_strb);
            drive4(v.slv, v.slv_rdata, v.slv_err, (k == v.waits + 1));
        end
        @(negedge P_clk);
        drive4(v.slv, v.slv_rdata, v.slv_err, 1'b0);
        check("done_valid",   if4.valid,    1'b1);
        check("done_error",   if4.error,    v.exp_error);
        check("done_timeout", if4.timeout,  1'b0);
        check("done_rdata",   if4.rdata,    v.exp_rdata);
        check("done_busy",    if4.busy,     1'b0);
        check("done_sel",     if4.P_sel,    4'b0000);
        check("done_en",      if4.P_enable, 1'b0);
        @(negedge P_clk);
        check("post_valid", if4.valid, 1'b0);
        check("post_error", if4.error, 1'b0);
    endtask

`ifdef APB_TIMEOUT_EN
    int  n_acc;
    logic got_valid;
`endif

    initial begin
        //          rw    addr   wdata          wstrb waits slv slv_rdata     err   sel      strb     error exp_rdata
        vecs[0] = '{1'b1, 8'h85, 32'hDEADBEEF, 4'hF, 0, 2, 32'h0000_0000, 1'b0, 4'b0100, 4'hF, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 8'h5C, 32'h0000_0000, 4'hA, 3, 1, 32'h1234_5678, 1'b0, 4'b0010, 4'h0, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 8'h10, 32'h0BADF00D, 4'h3, 1, 0, 32'h9999_9999, 1'b1, 4'b0001, 4'h3, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b0, 8'hF4, 32'h0000_0000, 4'h0, 2, 3, 32'hCAFE_0003, 1'b1, 4'b1000, 4'h0, 1'b1, 32'hCAFE_0003};
        vecs[4] = '{1'b0, 8'h3C, 32'h1111_1111, 4'hF, 0, 0, 32'hA5A5_0000, 1'b0, 4'b0001, 4'h0, 1'b0, 32'hA5A5_0000};
        vecs[5] = '{1'b1, 8'hC1, 32'h0000_00EE, 4'h8, 0, 3, 32'h4444_4444, 1'b0, 4'b1000, 4'h8, 1'b0, 32'hA5A5_0000};

        P_reset_n          = 1'b0;
        if4.start_transfer = 1'b0;
        if4.rw             = 1'b0;
        if4.addr           = '0;
        if4.wdata          = '0;
        if4.wstrb          = '0;
        drive4(0, 32'h0, 1'b0, 1'b0);
        if3.start_transfer = 1'b0;
        if3.rw             = 1'b0;
        if3.addr           = '0;
        if3.wdata          = '0;
        if3.wstrb          = '0;
        if3.P_rdata        = '0;
        if3.P_ready        = '0;
        if3.P_slverr       = '0;

        // Reset state
        repeat (2) @(negedge P_clk);
        check("rst_sel",     if4.P_sel,    4'b0000);
        check("rst_en",      if4.P_enable, 1'b0);
        check("rst_write",   if4.P_write,  1'b0);
        check("rst_addr",    if4.P_addr,   8'h00);
        check("rst_wdata",   if4.P_wdata,  32'h0);
        check("rst_strb",    if4.P_strb,   4'h0);
        check("rst_rdata",   if4.rdata,    32'h0);
        check("rst_valid",   if4.valid,    1'b0);
        check("rst_error",   if4.error,    1'b0);
        check("rst_timeout", if4.timeout,  1'b0);
        check("rst_busy",    if4.busy,     1'b0);
        check("rst3_busy",   if3.busy,     1'b0);
        P_reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: read slave 1, then a write to slave 2 held pending while busy
        @(negedge P_clk);
        request4(1'b0, 8'h44, 32'h0, 4'h0);
        drive4(1, 32'h1111_2222, 1'b0, 1'b0);
        @(negedge P_clk);
        check("b2b_setup_sel", if4.P_sel, 4'b0010);
        request4(1'b1, 8'h88, 32'h55AA_55AA, 4'h6);
        @(negedge P_clk);
        check("b2b_busy_addr",  if4.P_addr,   8'h44);
        check("b2b_busy_write", if4.P_write,  1'b0);
        check("b2b_access_en",  if4.P_enable, 1'b1);
        drive4(1, 32'h1111_2222, 1'b0, 1'b1);
        @(negedge P_clk);
        check("b2b_valid1", if4.valid, 1'b1);
        check("b2b_rdata1", if4.rdata, 32'h1111_2222);
        check("b2b_busy1",  if4.busy,  1'b0);
        drive4(2, 32'h0, 1'b0, 1'b0);
        @(negedge P_clk);
        check("b2b_setup2_sel",   if4.P_sel,    4'b0100);
        check("b2b_setup2_write", if4.P_write,  1'b1);
        check("b2b_setup2_addr",  if4.P_addr,   8'h88);
        check("b2b_setup2_wdata", if4.P_wdata,  32'h55AA_55AA);
        check("b2b_setup2_strb",  if4.P_strb,   4'h6);
        check("b2b_setup2_en",    if4.P_enable, 1'b0);
        check("b2b_setup2_valid", if4.valid,    1'b0);
        @(negedge P_clk);
        check("b2b_access2_en", if4.P_enable, 1'b1);
        drive4(2, 32'h0, 1'b0, 1'b1);
        @(negedge P_clk);
        check("b2b_valid2", if4.valid, 1'b1);
        check("b2b_error2", if4.error, 1'b0);
        check("b2b_rdata2", if4.rdata, 32'h1111_2222);
        if4.start_transfer = 1'b0;
        drive4(2, 32'h0, 1'b0, 1'b0);
        @(negedge P_clk);
        check("b2b_no_queue_busy",  if4.busy,  1'b0);
        check("b2b_no_queue_valid", if4.valid, 1'b0);
        check("b2b_no_queue_sel",   if4.P_sel, 4'b0000);

        // Decode error on the 3-slave instance: index 3 is out of range
        @(negedge P_clk);
        if3.P_ready        = 3'b111;
        if3.start_transfer = 1'b1;
        if3.rw             = 1'b1;
        if3.addr           = 8'hC5;
        @(negedge P_clk);
        if3.start_transfer = 1'b0;
        check("derr_sel",   if3.P_sel,    3'b000);
        check("derr_en",    if3.P_enable, 1'b0);
        check("derr_busy",  if3.busy,     1'b1);
        check("derr_valid", if3.valid,    1'b0);
        @(negedge P_clk);
        check("derr_done_valid",   if3.valid,   1'b1);
        check("derr_done_error",   if3.error,   1'b1);
        check("derr_done_timeout", if3.timeout, 1'b0);
        check("derr_done_busy",    if3.busy,    1'b0);
        check("derr_done_sel",     if3.P_sel,   3'b000);
        // Legal read from slave 2 of the same instance, zero waits
        if3.start_transfer = 1'b1;
        if3.rw             = 1'b0;
        if3.addr           = 8'h90;
        if3.P_rdata        = {32'h3333_4444, 32'hEEEE_EEEE, 32'hDDDD_DDDD};
        @(negedge P_clk);
        if3.start_transfer = 1'b0;
        check("n3_setup_sel", if3.P_sel, 3'b100);
        @(negedge P_clk);
        check("n3_access_en", if3.P_enable, 1'b1);
        @(negedge P_clk);
        check("n3_valid", if3.valid, 1'b1);
        check("n3_error", if3.error, 1'b0);
        check("n3_rdata", if3.rdata, 32'h3333_4444);

`ifdef APB_TIMEOUT_EN
        // Slave 0 never ready: abort after 8 ACCESS cycles
        @(negedge P_clk);
        request4(1'b0, 8'h20, 32'h0, 4'h0);
        drive4(0, 32'h7777_7777, 1'b0, 1'b0);
        @(negedge P_clk);
        if4.start_transfer = 1'b0;
        n_acc     = 0;
        got_valid = 1'b0;
        for (int c = 0; c < 20 && !got_valid; c++) begin
            @(negedge P_clk);
            if (if4.valid) got_valid = 1'b1;
            else if (if4.P_enable) n_acc++;
        end
        check("to_valid_seen",    got_valid,    1'b1);
        check("to_access_cycles", n_acc,        8);
        check("to_error",         if4.error,    1'b1);
        check("to_timeout",       if4.timeout,  1'b1);
        check("to_rdata",         if4.rdata,    32'h1111_2222);
        check("to_sel",           if4.P_sel,    4'b0000);
        check("to_en",            if4.P_enable, 1'b0);
        // Ready on the limit cycle wins
        request4(1'b0, 8'h20, 32'h0, 4'h0);
        @(negedge P_clk);
        if4.start_transfer = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge P_clk);
            check("lim_access_en", if4.P_enable, 1'b1);
            drive4(0, 32'h7777_7777, 1'b0, (k == 8));
        end
        @(negedge P_clk);
        drive4(0, 32'h7777_7777, 1'b0, 1'b0);
        check("lim_valid",   if4.valid,   1'b1);
        check("lim_error",   if4.error,   1'b0);
        check("lim_timeout", if4.timeout, 1'b0);
        check("lim_rdata",   if4.rdata,   32'h7777_7777);
`endif

        // Reset pulsed mid-ACCESS: everything clears, no completion follows
        @(negedge P_clk);
        request4(1'b1, 8'h47, 32'h1357_2468, 4'hF);
        drive4(1, 32'h0, 1'b0, 1'b0);
        @(negedge P_clk);
        if4.start_transfer = 1'b0;
        @(negedge P_clk);
        check("mid_access_en", if4.P_enable, 1'b1);
        @(negedge P_clk);
        P_reset_n = 1'b0;
        @(negedge P_clk);
        check("mid_rst_sel",     if4.P_sel,    4'b0000);
        check("mid_rst_en",      if4.P_enable, 1'b0);
        check("mid_rst_write",   if4.P_write,  1'b0);
        check("mid_rst_addr",    if4.P_addr,   8'h00);
        check("mid_rst_wdata",   if4.P_wdata,  32'h0);
        check("mid_rst_strb",    if4.P_strb,   4'h0);
        check("mid_rst_rdata",   if4.rdata,    32'h0);
        check("mid_rst_valid",   if4.valid,    1'b0);
        check("mid_rst_error",   if4.error,    1'b0);
        check("mid_rst_timeout", if4.timeout,  1'b0);
        check("mid_rst_busy",    if4.busy,     1'b0);
        P_reset_n = 1'b1;
        drive4(1, 32'h0, 1'b0, 1'b1);
        @(negedge P_clk);
        check("post_rst_valid", if4.valid,    1'b0);
        check("post_rst_busy",  if4.busy,     1'b0);
        check("post_rst_en",    if4.P_enable, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
